// File: rtl/result_sel_pipe_pkg.sv
// result_sel_pipe_pkg: shared mode encoding and payload sizing for result_sel_pipe
//   Holds the selection op encoding (MODE_PASS/OVERLAY/CMP_ONLY/SAT) and the
//   skid payload width: result + carry, plus two flag bits when the optional
//   RESULT_SEL_FLAGS_EN macro is defined.
`ifndef RESULT_SEL_PIPE_PKG_SV
`define RESULT_SEL_PIPE_PKG_SV
package result_sel_pipe_pkg;

    typedef enum logic [1:0] {
        MODE_PASS     = 2'b00,
        MODE_OVERLAY  = 2'b01,
        MODE_CMP_ONLY = 2'b10,
        MODE_SAT      = 2'b11
    } mode_e;

`ifdef RESULT_SEL_FLAGS_EN
    localparam int FLAG_W = 2;
`else
    localparam int FLAG_W = 0;
`endif

    function automatic int payload_w(int n);
        return n + 1 + FLAG_W;
    endfunction

endpackage
`endif

// File: rtl/result_sel_skid.sv
// result_sel_skid: generic 2-entry valid/ready skid buffer (output register + skid entry)
//   clk, rst           : clock, synchronous active-high reset
//   in_valid_i/in_ready_o/in_data_i    : upstream handshake; in_ready_o is registered
//   out_valid_o/out_ready_i/out_data_o : downstream handshake from the output register
module result_sel_skid #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    logic         main_v_q, main_v_d, skid_v_q, skid_v_d, rdy_q;
    logic [W-1:0] main_q, main_d, skid_q, skid_d;
    logic         in_fire, out_fire, load_main;

    // Main reloads whenever it is empty or draining; the skid entry always has
    // priority so order is preserved. in_ready is low whenever skid is full,
    // so an accept never coincides with a full skid entry.
    always_comb begin
        in_fire   = in_valid_i && rdy_q;
        out_fire  = main_v_q && out_ready_i;
        load_main = !main_v_q || out_fire;
        main_v_d  = load_main ? (skid_v_q || in_fire) : main_v_q;
        main_d    = (load_main && skid_v_q) ? skid_q :
                    (load_main && in_fire)  ? in_data_i : main_q;
        skid_v_d  = skid_v_q ? !out_fire : (in_fire && !load_main);
        skid_d    = (in_fire && !load_main) ? in_data_i : skid_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            rdy_q    <= 1'b1;
            main_q   <= '0;
            skid_q   <= '0;
        end else begin
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
            rdy_q    <= !skid_v_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
        end
    end

    assign in_ready_o  = rdy_q;
    assign out_valid_o = main_v_q;
    assign out_data_o  = main_q;

endmodule

// File: rtl/result_sel_pipe.sv
// result_sel_pipe: registered, handshaked result/carry selector between adder/comparator and consumer
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid/in_ready        : input handshake (in_ready registered)
//   sum, co, com_res, mode   : adder sum/carry, comparator result, selection op
//   out_valid/out_ready      : output handshake
//   sel_res, sel_co          : selected result and carry (registered)
//   res_zero, res_sat        : only with RESULT_SEL_FLAGS_EN; zero result / SAT clipped
module result_sel_pipe
    import result_sel_pipe_pkg::*;
#(
    parameter int N  = 16,
    parameter int CW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  sum,
    input  logic          co,
    input  logic [CW-1:0] com_res,
    input  logic [1:0]    mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  sel_res,
`ifdef RESULT_SEL_FLAGS_EN
    output logic          res_zero,
    output logic          res_sat,
`endif
    output logic          sel_co
);

    localparam int PW = payload_w(N);

    logic [N-1:0]  res;
    logic          res_co;
    logic [PW-1:0] in_data, out_data;

    // Unknown or PASS op falls through to the default: sum and carry unchanged.
    always_comb begin
        res    = sum;
        res_co = co;
        case (mode)
            MODE_OVERLAY:  res[CW-1:0] = com_res;
            MODE_CMP_ONLY: begin
                res    = N'(com_res);
                res_co = 1'b0;
            end
            MODE_SAT: begin
                res    = co ? '1 : sum;
                res_co = 1'b0;
            end
            default: ;
        endcase
    end

`ifdef RESULT_SEL_FLAGS_EN
    assign in_data  = {mode == MODE_SAT && co, res == '0, res_co, res};
    assign res_sat  = out_data[N+2];
    assign res_zero = out_data[N+1];
`else
    assign in_data  = {res_co, res};
`endif

    result_sel_skid #(.W(PW)) u_skid (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data)
    );

    assign sel_res = out_data[N-1:0];
    assign sel_co  = out_data[N];

endmodule
